// File: rtl/cache_bus_arbiter.sv
// Arbitrates icache reads, dcache reads and dcache write-backs onto one memory bus,
// one transaction at a time. Define CACHE_ARB_RR_EN for round-robin read priority.
module cache_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_ret_data,
    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_ret_data,
    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [127:0]      d_wr_data,
    output logic              d_wr_rdy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_len,
    output logic [2:0]        mem_size,
    input  logic              mem_addr_ok,
    output logic              mem_wvalid,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              mem_wlast,
    input  logic              mem_wready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rlast,
    input  logic              mem_bvalid
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;

    logic [2:0]        state;
    logic              gnt_d;
    logic [2:0]        lat_type;
    logic [ADDR_W-1:0] lat_addr;
    logic [127:0]      lat_data;
    logic [3:0]        lat_wstrb;
    logic [1:0]        cnt;
    logic              idle, is_line, prio_d, g_wr, g_dr, g_ir, rd_data, wr_data;

    assign idle    = (state == IDLE);
    assign rd_data = (state == RD_DATA);
    assign wr_data = (state == WR_DATA);
    assign is_line = (lat_type == 3'b100);

`ifdef CACHE_ARB_RR_EN
    logic rr_ptr;
    assign prio_d = ~rr_ptr;

    // Pointer ends up favouring whichever cache did not win the last read grant.
    always_ff @(posedge clk) begin
        if (!resetn)
            rr_ptr <= 1'b0;
        else if (g_dr || g_ir)
            rr_ptr <= g_dr;
    end
`else
    assign prio_d = 1'b1;
`endif

    assign g_wr = idle & d_wr_req;
    assign g_dr = idle & ~d_wr_req & d_rd_req & (~i_rd_req | prio_d);
    assign g_ir = idle & ~d_wr_req & i_rd_req & (~d_rd_req | ~prio_d);

    assign d_wr_rdy = g_wr;
    assign d_rd_rdy = g_dr;
    assign i_rd_rdy = g_ir;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            cnt       <= 2'd0;
            lat_type  <= 3'd0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_wstrb <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (g_wr) begin
                        state     <= WR_ADDR;
                        gnt_d     <= 1'b1;
                        lat_type  <= d_wr_type;
                        lat_addr  <= d_wr_addr;
                        lat_data  <= d_wr_data;
                        lat_wstrb <= d_wr_wstrb;
                    end else if (g_dr) begin
                        state    <= RD_ADDR;
                        gnt_d    <= 1'b1;
                        lat_type <= d_rd_type;
                        lat_addr <= d_rd_addr;
                    end else if (g_ir) begin
                        state    <= RD_ADDR;
                        gnt_d    <= 1'b0;
                        lat_type <= i_rd_type;
                        lat_addr <= i_rd_addr;
                    end
                end
                RD_ADDR: if (mem_addr_ok) state <= RD_DATA;
                RD_DATA: if (mem_rvalid && mem_rlast) state <= IDLE;
                WR_ADDR: begin
                    cnt <= 2'd0;
                    if (mem_addr_ok) state <= WR_DATA;
                end
                WR_DATA: begin
                    if (mem_wready) begin
                        if (mem_wlast) begin
                            state <= WR_RESP;
                            cnt   <= 2'd0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                WR_RESP: if (mem_bvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req  = (state == RD_ADDR) | (state == WR_ADDR);
    assign mem_we   = (state == WR_ADDR);
    assign mem_addr = lat_addr;
    assign mem_len  = is_line ? 2'd3 : 2'd0;
    assign mem_size = is_line ? 3'b010 : {1'b0, lat_type[1:0]};

    assign mem_wvalid = wr_data;
    assign mem_wdata  = wr_data ? lat_data[{cnt, 5'b0} +: 32] : 32'd0;
    assign mem_wstrb  = wr_data ? (is_line ? 4'hF : lat_wstrb) : 4'd0;
    assign mem_wlast  = wr_data & (cnt == mem_len);

    // Read beats pass straight through to the grantee in the same cycle.
    assign i_ret_valid = rd_data & ~gnt_d & mem_rvalid;
    assign i_ret_last  = i_ret_valid & mem_rlast;
    assign i_ret_data  = i_ret_valid ? mem_rdata : 32'd0;
    assign d_ret_valid = rd_data & gnt_d & mem_rvalid;
    assign d_ret_last  = d_ret_valid & mem_rlast;
    assign d_ret_data  = d_ret_valid ? mem_rdata : 32'd0;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter: directed requests, a behavioural memory
// slave, and a monitor that pops expected grants, commands, beats and returns.
module tb_cache_bus_arbiter;
    logic clk = 0, resetn = 0;
    logic i_rd_req = 0; logic [2:0] i_rd_type = 0; logic [31:0] i_rd_addr = 0;
    logic d_rd_req = 0; logic [2:0] d_rd_type = 0; logic [31:0] d_rd_addr = 0;
    logic d_wr_req = 0; logic [2:0] d_wr_type = 0; logic [31:0] d_wr_addr = 0;
    logic [3:0] d_wr_wstrb = 0; logic [127:0] d_wr_data = 0;
    logic i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy;
    logic [31:0] i_ret_data, d_ret_data, mem_addr, mem_wdata;
    logic mem_req, mem_we, mem_wvalid, mem_wlast;
    logic [1:0] mem_len; logic [2:0] mem_size; logic [3:0] mem_wstrb;
    logic mem_addr_ok = 0, mem_wready = 0, mem_rvalid = 0, mem_rlast = 0, mem_bvalid = 0;
    logic [31:0] mem_rdata = 0;

    cache_bus_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_size(mem_size), .mem_addr_ok(mem_addr_ok), .mem_wvalid(mem_wvalid),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast), .mem_bvalid(mem_bvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [1:0] len; logic [2:0] size; int cyc; } cmd_t;
    typedef struct { logic [31:0] d; logic l; } ret_t;
    typedef struct { logic [31:0] d; logic [3:0] s; logic l; } wb_t;
    cmd_t cmd_q[$]; ret_t iret_q[$]; ret_t dret_q[$]; wb_t wb_q[$]; int gnt_q[$];

    int checks = 0, passes = 0, cyc = 0, last_b = -100, req_cyc = 0;
    bit raw_chk = 0;
    logic [31:0] first_addr;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory slave: driven at posedge+2 so it sees requests and resetn already updated.
    int ok_delay = 0, rs = 0, wcnt = 0, beat = 0, nbeats = 0, bcnt = 0;
    logic r_we; logic [31:0] r_addr;
    initial begin
        forever begin
            @(posedge clk); #2;
            mem_addr_ok = 0; mem_rvalid = 0; mem_rlast = 0; mem_rdata = 0;
            mem_bvalid = 0; mem_wready = 0;
            if (!resetn) rs = 0;
            else begin
                if (rs == 0 && mem_req === 1'b1) begin
                    rs = 1; wcnt = 0; beat = 0; r_we = mem_we; r_addr = mem_addr;
                    nbeats = int'(mem_len) + 1;
                end
                if (rs == 1) begin
                    if (wcnt == ok_delay) begin mem_addr_ok = 1; rs = r_we ? 3 : 2; end
                    else wcnt++;
                end else if (rs == 2) begin
                    mem_rvalid = 1; mem_rdata = 32'hA000_0000 + r_addr + 32'(beat * 16);
                    mem_rlast = (beat == nbeats - 1); beat++;
                    if (mem_rlast) rs = 0;
                end else if (rs == 3) begin
                    mem_wready = 1;
                    if (mem_wvalid && mem_wlast) begin rs = 4; bcnt = 0; end
                end else if (rs == 4) begin
                    bcnt++;
                    if (bcnt == 2) begin mem_bvalid = 1; rs = 0; end
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents something.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) req_cyc = 0;
            if (mem_bvalid) last_b = cyc;
            if ((i_rd_rdy | d_rd_rdy | d_wr_rdy) === 1'b1) begin
                int code;
                code = d_wr_rdy ? 2 : (d_rd_rdy ? 1 : 0);
                chk("rdy_onehot", 160'(int'(i_rd_rdy) + int'(d_rd_rdy) + int'(d_wr_rdy)), 160'd1);
                if (gnt_q.size() == 0) chk("grant_unexpected", 160'(code), 160'hFF);
                else chk("grant_id", 160'(code), 160'(gnt_q.pop_front()));
                if (raw_chk && code == 1) begin
                    chk("rd_after_bvalid", 160'(cyc - last_b), 160'd1);
                    raw_chk = 0;
                end
            end
            if (mem_req === 1'b1 && resetn) begin
                if (req_cyc == 0) first_addr = mem_addr;
                else chk("addr_stable", 160'(mem_addr), 160'(first_addr));
                req_cyc++;
                if (mem_addr_ok) begin
                    if (cmd_q.size() == 0) chk("cmd_unexpected", 160'(mem_addr), 160'hFF);
                    else begin
                        cmd_t c;
                        c = cmd_q.pop_front();
                        chk("cmd", {mem_we, mem_addr, mem_len, mem_size},
                            {c.we, c.addr, c.len, c.size});
                        chk("cmd_req_cycles", 160'(req_cyc), 160'(c.cyc));
                    end
                    req_cyc = 0;
                end
            end
            if (i_ret_valid === 1'b1) begin
                if (iret_q.size() == 0) chk("i_ret_unexpected", 160'(i_ret_data), 160'hFF);
                else begin
                    ret_t r;
                    r = iret_q.pop_front();
                    chk("i_ret", {i_ret_data, i_ret_last}, {r.d, r.l});
                end
            end
            if (d_ret_valid === 1'b1) begin
                if (dret_q.size() == 0) chk("d_ret_unexpected", 160'(d_ret_data), 160'hFF);
                else begin
                    ret_t r;
                    r = dret_q.pop_front();
                    chk("d_ret", {d_ret_data, d_ret_last}, {r.d, r.l});
                end
            end
            if (mem_wvalid === 1'b1 && mem_wready) begin
                if (wb_q.size() == 0) chk("wbeat_unexpected", 160'(mem_wdata), 160'hFF);
                else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wbeat", {mem_wdata, mem_wstrb, mem_wlast}, {w.d, w.s, w.l});
                end
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    function automatic logic rdy_of(input int which);
        return which == 0 ? i_rd_rdy : (which == 1 ? d_rd_rdy : (which == 2 ? d_wr_rdy :
               (i_rd_rdy | d_rd_rdy | d_wr_rdy)));
    endfunction

    // Called at posedge+1 with the request already driven; returns at posedge+1 after grant.
    task automatic wait_rdy(input int which);
        bit ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            #2;
            if (rdy_of(which) === 1'b1) ok = 1;
            tick();
        end
        if (!ok) chk("rdy_timeout", 160'(which), 160'hFF);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cmd_q.size() + iret_q.size() + dret_q.size() + wb_q.size() + gnt_q.size() != 0
                || rs != 0) && n < 300) begin
            tick(); n++;
        end
        if (n >= 300) chk("idle_timeout", 160'(n), 160'd0);
        tick();
    endtask

    task automatic chk_zero(input string name);
        @(negedge clk); #1;
        chk(name, {i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data, d_rd_rdy, d_ret_valid,
                   d_ret_last, d_ret_data, d_wr_rdy, mem_req, mem_we, mem_addr, mem_len,
                   mem_size, mem_wvalid, mem_wdata, mem_wstrb, mem_wlast}, 160'd0);
    endtask

    task automatic apply_reset();
        tick(); resetn = 0; tick(); tick(); resetn = 1; tick();
    endtask

    function automatic cmd_t mk(input logic we, input logic [31:0] a, input logic [1:0] l,
                                input logic [2:0] s, input int c);
        cmd_t x; x.we = we; x.addr = a; x.len = l; x.size = s; x.cyc = c; return x;
    endfunction
    function automatic ret_t rt(input logic [31:0] d, input logic l);
        ret_t x; x.d = d; x.l = l; return x;
    endfunction
    function automatic wb_t wb(input logic [31:0] d, input logic [3:0] s, input logic l);
        wb_t x; x.d = d; x.s = s; x.l = l; return x;
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        chk_zero("reset_outputs");
        tick(); resetn = 1; tick();

        // icache line read alone
        gnt_q.push_back(0); cmd_q.push_back(mk(0, 32'h1000, 2'd3, 3'b010, 1));
        iret_q.push_back(rt(32'hA000_1000, 0)); iret_q.push_back(rt(32'hA000_1010, 0));
        iret_q.push_back(rt(32'hA000_1020, 0)); iret_q.push_back(rt(32'hA000_1030, 1));
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1000;
        wait_rdy(0); i_rd_req = 0;
        wait_idle();

        // write-back line and dcache read in the same cycle: write first, read after bvalid
        gnt_q.push_back(2); gnt_q.push_back(1);
        cmd_q.push_back(mk(1, 32'h2000, 2'd3, 3'b010, 1));
        wb_q.push_back(wb(32'h1111_1111, 4'hF, 0)); wb_q.push_back(wb(32'h2222_2222, 4'hF, 0));
        wb_q.push_back(wb(32'h3333_3333, 4'hF, 0)); wb_q.push_back(wb(32'h4444_4444, 4'hF, 1));
        cmd_q.push_back(mk(0, 32'h2400, 2'd0, 3'b010, 1));
        dret_q.push_back(rt(32'hA000_2400, 1));
        raw_chk = 1;
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h2000; d_wr_wstrb = 4'h0;
        d_wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h2400;
        wait_rdy(2); d_wr_req = 0;
        wait_rdy(1); d_rd_req = 0;
        wait_idle();
        chk("raw_checked", 160'(raw_chk), 160'd0);

        // word write with partial strobe
        gnt_q.push_back(2); cmd_q.push_back(mk(1, 32'h2800, 2'd0, 3'b010, 1));
        wb_q.push_back(wb(32'hDEAD_BEEF, 4'b0011, 1));
        d_wr_req = 1; d_wr_type = 3'b010; d_wr_addr = 32'h2800; d_wr_wstrb = 4'b0011;
        d_wr_data = 128'h0123_4567_89AB_CDEF_0F0F_0F0F_DEAD_BEEF;
        wait_rdy(2); d_wr_req = 0;
        wait_idle();

        // slow mem_addr_ok: command held 6 cycles
        ok_delay = 5;
        gnt_q.push_back(0); cmd_q.push_back(mk(0, 32'h1400, 2'd0, 3'b010, 6));
        iret_q.push_back(rt(32'hA000_1400, 1));
        i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1400;
        wait_rdy(0); i_rd_req = 0;
        wait_idle();
        ok_delay = 0;

        // byte and half reads
        gnt_q.push_back(1); cmd_q.push_back(mk(0, 32'h2803, 2'd0, 3'b000, 1));
        dret_q.push_back(rt(32'hA000_2803, 1));
        d_rd_req = 1; d_rd_type = 3'b000; d_rd_addr = 32'h2803;
        wait_rdy(1); d_rd_req = 0;
        wait_idle();
        gnt_q.push_back(0); cmd_q.push_back(mk(0, 32'h1402, 2'd0, 3'b001, 1));
        iret_q.push_back(rt(32'hA000_1402, 1));
        i_rd_req = 1; i_rd_type = 3'b001; i_rd_addr = 32'h1402;
        wait_rdy(0); i_rd_req = 0;
        wait_idle();

        // reset in place of beat 2 of a line read: only beat 1 may appear
        gnt_q.push_back(0); cmd_q.push_back(mk(0, 32'h3000, 2'd3, 3'b010, 1));
        iret_q.push_back(rt(32'hA000_3000, 0));
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h3000;
        wait_rdy(0); i_rd_req = 0;
        n = 0;
        while (!(rs == 2 && beat == 1) && n < 100) begin tick(); n++; end
        if (n >= 100) chk("beat1_timeout", 160'(n), 160'd0);
        resetn = 0;
        tick();
        chk_zero("mid_burst_reset");
        tick(); resetn = 1;
        repeat (6) tick();
        wait_idle();

        // both read caches held for three transactions
        apply_reset();
`ifdef CACHE_ARB_RR_EN
        gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        cmd_q.push_back(mk(0, 32'h2200, 2'd0, 3'b010, 1)); dret_q.push_back(rt(32'hA000_2200, 1));
        cmd_q.push_back(mk(0, 32'h1100, 2'd0, 3'b010, 1)); iret_q.push_back(rt(32'hA000_1100, 1));
        cmd_q.push_back(mk(0, 32'h2200, 2'd0, 3'b010, 1)); dret_q.push_back(rt(32'hA000_2200, 1));
`else
        for (int k = 0; k < 3; k++) begin
            gnt_q.push_back(1);
            cmd_q.push_back(mk(0, 32'h2200, 2'd0, 3'b010, 1));
            dret_q.push_back(rt(32'hA000_2200, 1));
        end
`endif
        i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1100;
        d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h2200;
        for (int k = 0; k < 3; k++) wait_rdy(3);
        i_rd_req = 0; d_rd_req = 0;
        wait_idle();

        chk("leftover_expected",
            160'(cmd_q.size() + iret_q.size() + dret_q.size() + wb_q.size() + gnt_q.size()), 160'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all request and memory address ports.
REQ-002 clk  in  1  clock; all logic on posedge clk.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 i_rd_req / i_rd_type / i_rd_addr  in  1/3/ADDR_W  icache read request, type (3'b100 line, 3'b000 byte, 3'b001 half, 3'b010 word), address.
REQ-005 i_rd_rdy  out  1  one-cycle pulse when the icache read is accepted.
REQ-006 i_ret_valid / i_ret_last / i_ret_data  out  1/1/32  icache return beat, last beat, beat data.
REQ-007 d_rd_req / d_rd_type / d_rd_addr / d_rd_rdy / d_ret_valid / d_ret_last / d_ret_data  as REQ-004..006  dcache read channel.
REQ-008 d_wr_req / d_wr_type / d_wr_addr / d_wr_wstrb / d_wr_data  in  1/3/ADDR_W/4/128  dcache write-back request.
REQ-009 d_wr_rdy  out  1  one-cycle pulse when the write is accepted and buffered.
REQ-010 mem_req / mem_we / mem_addr / mem_len / mem_size  out  1/1/ADDR_W/2/3  memory command: valid, write, address, beats-1, size.
REQ-011 mem_addr_ok  in  1  memory accepts the command.
REQ-012 mem_wvalid / mem_wdata / mem_wstrb / mem_wlast  out  1/32/4/1  write beat; mem_wready  in  1.
REQ-013 mem_rvalid / mem_rdata / mem_rlast  in  1/32/1  read beat; mem_bvalid  in  1  write response.

Function
REQ-014 FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP; exactly one memory transaction outstanding.
REQ-015 IDLE priority: d_wr_req > d_rd_req > i_rd_req (fixed, see REQ-030); a write and a read in the same cycle -> write granted first.
REQ-016 Grant in IDLE: pulse matching rdy for that cycle, latch type/addr (and 128-bit data, wstrb for writes), grantee id; next state RD_ADDR or WR_ADDR.
REQ-017 rdy is never asserted outside IDLE; non-granted requests remain pending until a later IDLE grant.
REQ-018 Beats: type 3'b100 -> 4 beats, mem_len=2'd3, mem_size=3'b010; otherwise 1 beat, mem_len=0, mem_size={1'b0,type[1:0]}; mem_addr = latched address unchanged.
REQ-019 RD_ADDR / WR_ADDR: mem_req=1, mem_we=0/1, held stable until mem_addr_ok; then RD_DATA / WR_DATA.
REQ-020 RD_DATA: mem_rvalid/mem_rdata/mem_rlast forwarded combinationally, same cycle, to grantee's ret_valid/ret_data/ret_last; other cache's ret_valid=0; mem_rvalid&mem_rlast -> IDLE.
REQ-021 mem_rvalid outside RD_DATA ignored; no ret_valid generated.
REQ-022 WR_DATA: 2-bit beat counter from 0; mem_wvalid=1, mem_wdata=buf[32*cnt+31:32*cnt], mem_wstrb=4'hF for lines else latched wstrb; mem_wlast=(cnt==mem_len); counter increments on mem_wready.
REQ-023 mem_wready&mem_wlast -> WR_RESP; WR_RESP holds until mem_bvalid -> IDLE; no read granted before bvalid (no RAW hazard).
REQ-024 Return to IDLE costs one cycle; earliest next grant is the cycle after re-entering IDLE.
REQ-025 Outside their states: mem_req, mem_wvalid, mem_wlast, all rdy and ret_valid = 0.

Reset
REQ-026 resetn low at any clk edge -> IDLE, beat counter 0, grantee id 0, RR pointer 0, buffers discarded.
REQ-027 Reset values: all rdy, ret_valid, ret_last, mem_req, mem_we, mem_wvalid, mem_wlast = 0; data/address outputs = 0.
REQ-028 Reset mid-burst abandons the transaction; no further beats forwarded or driven after reset.

Configuration
REQ-029 Macro CACHE_ARB_RR_EN undefined: read priority fixed dcache > icache.
REQ-030 CACHE_ARB_RR_EN defined: 1-bit pointer chooses read priority when both read requests present; reset 0 = dcache first; toggles to favour the other cache after each read grant; writes keep top priority.

Verification
REQ-031 icache line read 0x1000 alone -> i_rd_rdy pulse, mem_len=3, 4 i_ret_valid beats, i_ret_last on beat 4, d_ret_valid=0 throughout.
REQ-032 d_wr_req (line 0x2000, data 128'h4444_..._1111) with d_rd_req same cycle -> d_wr_rdy first, beats 0x1111..,0x2222..,0x3333..,0x4444.. wlast on 4th, d_rd_rdy only after bvalid+1 cycle.
REQ-033 dcache word write wstrb 4'b0011 -> mem_len=0, one beat wstrb 4'b0011, wlast=1, mem_size=3'b010.
REQ-034 i_rd_req and d_rd_req held 3 transactions: fixed build -> d,d,d; CACHE_ARB_RR_EN -> d,i,d.
REQ-035 mem_addr_ok delayed 5 cycles -> mem_req/addr stable 6 cycles; resetn low during beat 2 of read -> IDLE, no further ret_valid.
